// File: rtl/color_window_classifier.sv
// Streaming RGB565 colour classifier: per-class min/max windows, 2-cycle match pipeline,
// and per-class matched-pixel counts latched at each frame boundary.
module color_window_classifier #(
    parameter int NR_CLASSES  = 4,
    parameter int COUNT_WIDTH = 20,
    localparam int SEL_W      = (NR_CLASSES > 1) ? $clog2(NR_CLASSES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfgWe,
    input  logic [SEL_W-1:0]       cfgClass,
    input  logic [31:0]            cfgData,
    input  logic [NR_CLASSES-1:0]  cfgEnable,
    input  logic                   pixelValid,
    input  logic [15:0]            pixelData,
    input  logic                   frameStart,
    output logic                   matchValid,
    output logic [NR_CLASSES-1:0]  matchMask,
    output logic                   matchAny,
    output logic                   frameDone,
    input  logic [SEL_W-1:0]       countSel,
    output logic [COUNT_WIDTH-1:0] countValue
);

    localparam logic [31:0] EMPTY_WINDOW = {5'd31, 5'd0, 6'd63, 6'd0, 5'd31, 5'd0};
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
    localparam int SEL_SPAN = 1 << SEL_W;

    logic [31:0]            thresholds [NR_CLASSES];
    logic [15:0]            s1Data;
    logic                   s1Valid;
    logic                   s1Frame;
    logic [NR_CLASSES-1:0]  s1Enable;
    logic [NR_CLASSES-1:0]  windowHit;
    logic                   frameAtOutput;
    logic                   seenFrame;
    logic [COUNT_WIDTH-1:0] runningCount [NR_CLASSES];
    logic [COUNT_WIDTH-1:0] resultCount  [NR_CLASSES];
    logic [COUNT_WIDTH-1:0] countTable   [SEL_SPAN];
    logic [4:0]             pixR;
    logic [5:0]             pixG;
    logic [4:0]             pixB;

    // Class selects beyond NR_CLASSES simply match no register, so such writes drop out.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NR_CLASSES; k++) thresholds[k] <= EMPTY_WINDOW;
        end else begin
            for (int k = 0; k < NR_CLASSES; k++) begin
                if (cfgWe && cfgClass == SEL_W'(k)) thresholds[k] <= cfgData;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1Data   <= '0;
            s1Valid  <= 1'b0;
            s1Frame  <= 1'b0;
            s1Enable <= '0;
        end else begin
            s1Data   <= pixelData;
            s1Valid  <= pixelValid;
            s1Frame  <= frameStart;
            s1Enable <= cfgEnable;
        end
    end

    assign pixR = s1Data[15:11];
    assign pixG = s1Data[10:5];
    assign pixB = s1Data[4:0];

    always_comb begin
        windowHit = '0;
        for (int k = 0; k < NR_CLASSES; k++) begin
            windowHit[k] = (pixR >= thresholds[k][31:27]) && (pixR <= thresholds[k][26:22]) &&
                           (pixG >= thresholds[k][21:16]) && (pixG <= thresholds[k][15:10]) &&
                           (pixB >= thresholds[k][9:5])   && (pixB <= thresholds[k][4:0]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            matchValid    <= 1'b0;
            matchMask     <= '0;
            frameAtOutput <= 1'b0;
        end else begin
            matchValid    <= s1Valid;
            matchMask     <= windowHit & s1Enable & {NR_CLASSES{s1Valid}};
            frameAtOutput <= s1Frame;
        end
    end

    assign matchAny = |matchMask;

    // At a boundary the pixel on the output belongs to the new frame, so it seeds the
    // running counter instead of being added to the count that gets latched.
    always_ff @(posedge clock) begin
        if (reset) begin
            seenFrame <= 1'b0;
            frameDone <= 1'b0;
            for (int k = 0; k < NR_CLASSES; k++) begin
                runningCount[k] <= '0;
                resultCount[k]  <= '0;
            end
        end else begin
            frameDone <= 1'b0;
            if (frameAtOutput) begin
                seenFrame <= 1'b1;
                if (seenFrame) begin
                    frameDone <= 1'b1;
                    for (int k = 0; k < NR_CLASSES; k++) resultCount[k] <= runningCount[k];
                end
                for (int k = 0; k < NR_CLASSES; k++) runningCount[k] <= COUNT_WIDTH'(matchMask[k]);
            end else begin
                for (int k = 0; k < NR_CLASSES; k++) begin
                    if (matchMask[k] && runningCount[k] != COUNT_MAX)
                        runningCount[k] <= runningCount[k] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < SEL_SPAN; i++) begin : gCountTable
        if (i < NR_CLASSES) begin : gUsed
            assign countTable[i] = resultCount[i];
        end else begin : gUnused
            assign countTable[i] = '0;
        end
    end

    assign countValue = countTable[countSel];

endmodule

// File: doc/color_window_classifier.md
# color_window_classifier

Streaming multi-class colour classifier for the camera pixel path. Each RGB565 pixel is compared against `NR_CLASSES` runtime-programmable inclusive min/max windows, one window per channel per class. Output is a per-pixel class mask after a fixed 2-cycle pipeline. Per-class matched-pixel counts are accumulated per frame and latched at each frame boundary for the processor to read.

## Interface
Parameters:
- `NR_CLASSES`, 4, number of colour classes (1..8)
- `COUNT_WIDTH`, 20, width of per-class pixel counters

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `cfgWe`  in  1  write strobe for the threshold register of class `cfgClass`
- `cfgClass`  in  $clog2(NR_CLASSES) (min 1)  target class of the write
- `cfgData`  in  32  packed window: [31:27] rMin, [26:22] rMax, [21:16] gMin, [15:10] gMax, [9:5] bMin, [4:0] bMax
- `cfgEnable`  in  NR_CLASSES  per-class enable, sampled every cycle in stage 1
- `pixelValid`  in  1  pixel qualifier; no backpressure
- `pixelData`  in  16  RGB565: R=[15:11], G=[10:5], B=[4:0]
- `frameStart`  in  1  one-cycle pulse; marks its own pixel (if valid) as the first of a new frame
- `matchValid`  out  1  `pixelValid` delayed 2 cycles
- `matchMask`  out  NR_CLASSES  bit k = pixel inside class-k window and class enabled
- `matchAny`  out  1  OR of `matchMask`
- `frameDone`  out  1  one-cycle pulse when counts are latched
- `countSel`  in  $clog2(NR_CLASSES) (min 1)  latched-count select
- `countValue`  out  COUNT_WIDTH  latched count of class `countSel`

## Operation
- Threshold registers: one 32-bit register per class. Reset value: rMin=31, rMax=0, gMin=63, gMax=0, bMin=31, bMax=0 (empty window; never matches).
- `cfgWe` writes at the clock edge. A write with `cfgClass >= NR_CLASSES` is ignored.
- Stage 1 registers `pixelData`, `pixelValid`, `frameStart`, and `cfgEnable`.
- Stage 2 compares unsigned and inclusive: min <= channel <= max for R, G, and B. The comparison uses the threshold registers as they hold in that cycle. A window with min > max never matches.
- Stage 2 outputs are registered:
  - `matchValid` = stage-1 valid.
  - `matchMask` = compare result AND stage-1 enable AND stage-1 valid. It is 0 whenever `matchValid` = 0.
- Running counters: one per class. Each increments by 1 on a cycle where its `matchMask` bit is 1. Counters saturate at 2^COUNT_WIDTH-1.
- Frame boundary: `frameStart` travels through the pipeline alongside the pixel. When it reaches stage 2, in the same edge:
  - Each result register loads its running counter's value, excluding the current pixel.
  - Each running counter loads 1 if the current pixel matches its class, else 0.
  - `frameDone` pulses in the following cycle.
- First boundary after reset: the counters are cleared and reload as above, but neither the result registers nor `frameDone` are updated. A flag `seenFrame` (reset 0) tracks this.
- `frameStart` with `pixelValid`=0 is legal; the boundary is still processed.
- `countValue`: combinational mux of the result registers. An out-of-range `countSel` returns 0.
- Reset mid-frame: all pipeline valids, masks, running counters, result registers, `seenFrame`, and thresholds return to reset values. In-flight pixels are dropped.

## Timing
- Latency: pixel presented in cycle t → `matchValid`/`matchMask`/`matchAny` valid in cycle t+2. Throughput is 1 pixel/cycle.
- Config write in cycle t affects pixels presented in cycle t or later. It does not affect pixels presented in t-1 or earlier.
- `frameStart` in cycle t:
  - result registers updated at end of cycle t+2;
  - `frameDone`=1 in cycle t+3 and `countValue` reflects new counts from cycle t+3.
- Reset values of outputs: `matchValid`=0, `matchMask`=0, `matchAny`=0, `frameDone`=0, `countValue`=0.

## Test plan
- Window hit:
  - Stimulus: write class 0 with `cfgData`=0x860024CE (R 16..24, G 0..9, B 6..14), `cfgEnable`=4'b0001, then pixel 0xA0AA (R20 G5 B10).
  - Required: `matchMask`=4'b0001 and `matchAny`=1 exactly 2 cycles later.
- Inclusive bounds, same config:
  - Pixels 0x80AA (R16), 0xC0AA (R24), 0x78AA (R15), 0xC8AA (R25) back-to-back.
  - Required: masks 1, 1, 0, 0 on consecutive cycles.
- Enable/empty window:
  - After reset, pixel 0x0000 → mask 0.
  - Class 2 with window all-zero and `cfgEnable`[2]=0 → mask 0; set enable → mask 4'b0100.
- Frame counting:
  - `frameStart`, 10 pixels of 0xA0AA, then `frameStart` with pixel 0xA0AA. No `frameDone` for the first boundary.
  - Second boundary: `frameDone` 3 cycles after it, `countValue`(sel 0)=10, and running count restarts at 1.
- Saturation:
  - With `COUNT_WIDTH`=4: 20 matching pixels, then `frameStart` → `countValue`=15.
- Reset mid-frame and mid-pipeline:
  - Assert `reset` one cycle after a matching pixel.
  - Required: no `matchValid` pulse and `countValue`=0; thresholds revert, so the same pixel no longer matches without a rewrite.
